// File: rtl/dds_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : dds_pkg                                                      |
// | Brief  : Shared types and scale helpers for the DDS voice channels.   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package dds_pkg;

  typedef enum logic [1:0] {
    PULSE = 2'd0,
    SAW   = 2'd1,
    TRI   = 2'd2,
    RSVD  = 2'd3
  } wave_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } voice_state_e;

  // Offset-binary zero for a sample of the given width.
  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Largest positive two's-complement value for the given width.
  function automatic logic [31:0] full_scale(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_phase_acc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : dds_phase_acc                                                |
// | Brief  : Phase accumulator with enable, synchronous clear, a          |
// |          combinational carry for this step and a registered wrap.     |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module dds_phase_acc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_active_high,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] phase,
  output logic             carry,
  output logic             wrap
);

  logic [WIDTH:0] sum;

  assign sum   = {1'b0, phase} + {1'b0, inc};
  // Carry of the step that would be taken this cycle; lets the owner act on
  // the wrap in the same cycle it happens.
  assign carry = en & sum[WIDTH];

  // Advance the phase; clear dominates and suppresses the wrap pulse.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      if (en) begin
        phase <= sum[WIDTH-1:0];
      end
      wrap <= carry;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_pulse_voice.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : dds_pulse_voice                                              |
// | Brief  : DDS voice: pulse / saw / triangle from a phase accumulator,  |
// |          slew volume envelope with key gating, config handshake that  |
// |          applies on phase wrap. Offset-binary output.                 |
// | Macro  : DDS_PULSE_VOICE_TRI_EN builds the triangle generator;        |
// |          without it mode 2 plays as pulse.                            |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module dds_pulse_voice
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int VOL_WIDTH   = 6,
  parameter int DUTY_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_active_high,
  input  logic                   sample_en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic [DUTY_WIDTH-1:0]  cfg_duty,
  input  logic [VOL_WIDTH-1:0]   cfg_vol,
  input  logic [1:0]             cfg_mode,
  input  logic                   key_on,
  input  logic                   key_off,
  output logic [OUT_WIDTH-1:0]   wave_out,
  output logic                   wrap,
  output logic                   busy
);

  localparam logic [31:0] MID32  = midscale(OUT_WIDTH);
  localparam logic [31:0] FS32   = full_scale(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] MID = MID32[OUT_WIDTH-1:0];
  localparam logic signed [OUT_WIDTH-1:0] FS = FS32[OUT_WIDTH-1:0];
  localparam int PROD_W = OUT_WIDTH + VOL_WIDTH + 1;

  voice_state_e           state, state_next;
  logic [VOL_WIDTH-1:0]   cur_vol, vol_next;

  logic [PHASE_WIDTH-1:0] pend_freq, act_freq;
  logic [DUTY_WIDTH-1:0]  pend_duty, act_duty;
  logic [VOL_WIDTH-1:0]   pend_vol,  act_vol;
  wave_mode_e             pend_mode, act_mode;
  logic                   pend_flag;

  logic                   accept, apply;
  logic                   acc_en, acc_clr, acc_carry, end_rel;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   sample_d;

  logic signed [OUT_WIDTH-1:0] raw, raw_pulse, raw_saw;
  logic signed [PROD_W-1:0]    raw_ext, vol_ext, prod;
  logic [OUT_WIDTH-1:0]        wave_next;
  logic                        unused_bits;

  assign cfg_ready = ~pend_flag;
  assign busy      = (state != IDLE);
  assign acc_en    = sample_en & (state != IDLE);

  dds_phase_acc #(
    .WIDTH(PHASE_WIDTH)
  ) u_phase_acc (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .en              (acc_en),
    .clr             (acc_clr),
    .inc             (act_freq),
    .phase           (phase),
    .carry           (acc_carry),
    .wrap            (wrap)
  );

  // Voice state register together with the envelope level.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state   <= IDLE;
      cur_vol <= '0;
    end else begin
      state   <= state_next;
      cur_vol <= vol_next;
    end
  end

  // Next state, envelope step, and the config accept/apply decisions.
  always_comb begin
    state_next = state;
    vol_next   = cur_vol;
    end_rel    = 1'b0;

    case (state)
      RUN: begin
        if (sample_en) begin
          if (cur_vol < act_vol) begin
            vol_next = cur_vol + 1'b1;
          end else if (cur_vol > act_vol) begin
            vol_next = cur_vol - 1'b1;
          end
        end
        if (key_off) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (sample_en) begin
          vol_next = (cur_vol == '0) ? '0 : cur_vol - 1'b1;
          if (cur_vol <= VOL_WIDTH'(1)) begin
            end_rel    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        if (sample_en) begin
          vol_next = '0;
        end
      end
    endcase

    // key_on outranks key_off and the end of release; level is kept.
    if (key_on) begin
      state_next = RUN;
    end

    // Phase returns to zero on a new note and when the voice falls idle.
    acc_clr = key_on | end_rel;

    accept = cfg_valid & ~pend_flag;
    apply  = pend_flag & (key_on | (state == IDLE) | acc_carry);
  end

  // Pending/active register sets and the pending flag.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      pend_freq <= '0;
      pend_duty <= '0;
      pend_vol  <= '0;
      pend_mode <= PULSE;
      pend_flag <= 1'b0;
      act_freq  <= '0;
      act_duty  <= '0;
      act_vol   <= '0;
      act_mode  <= PULSE;
    end else if (apply) begin
      act_freq  <= pend_freq;
      act_duty  <= pend_duty;
      act_vol   <= pend_vol;
      act_mode  <= pend_mode;
      pend_flag <= 1'b0;
    end else if (accept) begin
      pend_freq <= cfg_freq;
      pend_duty <= cfg_duty;
      pend_vol  <= cfg_vol;
      pend_mode <= wave_mode_e'(cfg_mode);
      pend_flag <= 1'b1;
    end
  end

  assign raw_pulse = (phase[PHASE_WIDTH-1 -: DUTY_WIDTH] < act_duty) ? FS : -FS;
  // Top phase bits with the MSB flipped: offset-binary ramp read as signed.
  assign raw_saw   = {~phase[PHASE_WIDTH-1], phase[PHASE_WIDTH-2 -: OUT_WIDTH-1]};

`ifdef DDS_PULSE_VOICE_TRI_EN
  logic [OUT_WIDTH-1:0]        tri_seg, tri_fold;
  logic signed [OUT_WIDTH-1:0] raw_tri;

  if (PHASE_WIDTH > OUT_WIDTH) begin : g_tri_seg_full
    assign tri_seg = phase[PHASE_WIDTH-2 -: OUT_WIDTH];
  end else begin : g_tri_seg_pad
    assign tri_seg = {phase[PHASE_WIDTH-2:0], 1'b0};
  end

  // Second half of the period runs the ramp backwards; flipping the MSB
  // subtracts midscale.
  assign tri_fold = phase[PHASE_WIDTH-1] ? ~tri_seg : tri_seg;
  assign raw_tri  = {~tri_fold[OUT_WIDTH-1], tri_fold[OUT_WIDTH-2:0]};
`endif

  // Waveform select and volume scaling; bit-slicing the product is the
  // floor-shift by VOL_WIDTH.
  always_comb begin
    raw = raw_pulse;
    case (act_mode)
      SAW:     raw = raw_saw;
`ifdef DDS_PULSE_VOICE_TRI_EN
      TRI:     raw = raw_tri;
`endif
      default: raw = raw_pulse;
    endcase
    raw_ext   = {{(PROD_W-OUT_WIDTH){raw[OUT_WIDTH-1]}}, raw};
    vol_ext   = {{(PROD_W-VOL_WIDTH){1'b0}}, cur_vol};
    prod      = raw_ext * vol_ext;
    wave_next = prod[VOL_WIDTH +: OUT_WIDTH] + MID;
  end

  assign unused_bits = ^{phase, prod};

  // Output sample lags the phase/envelope update by one cycle.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      sample_d <= 1'b0;
      wave_out <= MID;
    end else begin
      sample_d <= sample_en;
      if (sample_d) begin
        wave_out <= wave_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_pulse_voice.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_dds_pulse_voice                                           |
// | Brief  : Directed and random stimulus against a behavioural model of  |
// |          the voice; every cycle is compared.                          |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_dds_pulse_voice;

  logic        clk = 1'b0;
  logic        rst_active_high = 1'b1;
  logic        sample_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_freq = '0;
  logic [7:0]  cfg_duty = '0;
  logic [5:0]  cfg_vol = '0;
  logic [1:0]  cfg_mode = '0;
  logic        key_on = 1'b0;
  logic        key_off = 1'b0;
  logic [15:0] wave_out;
  logic        wrap;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dds_pulse_voice dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .sample_en       (sample_en),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_freq        (cfg_freq),
    .cfg_duty        (cfg_duty),
    .cfg_vol         (cfg_vol),
    .cfg_mode        (cfg_mode),
    .key_on          (key_on),
    .key_off         (key_off),
    .wave_out        (wave_out),
    .wrap            (wrap),
    .busy            (busy)
  );

  // ---------------- behavioural model ----------------
  bit [31:0] m_phase, m_afreq, m_pfreq;
  int        m_vol, m_st;             // st: 0 idle, 1 run, 2 release
  int        m_aduty, m_avol, m_amode, m_pduty, m_pvol, m_pmode;
  bit        m_pflag, m_sd, m_wrap;
  int        m_wave;

  function automatic int exp_wave(bit [31:0] ph, int vol, int duty, int mode);
    int     raw;
    int     seg;
    int     md;
    longint p;
    md = mode;
`ifndef DDS_PULSE_VOICE_TRI_EN
    if (md == 2) md = 0;
`endif
    if (md == 1) begin
      raw = int'(ph >> 16) - 32768;
    end else if (md == 2) begin
      seg = int'((ph >> 15) & 32'hFFFF);
      if (ph[31]) seg = 65535 - seg;
      raw = seg - 32768;
    end else begin
      raw = (int'(ph >> 24) < duty) ? 32767 : -32767;
    end
    p = longint'(raw) * longint'(vol);
    p = p >>> 6;
    return int'((p + 64'sd32768) & 64'sh0000_FFFF);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_afreq = 0; m_pfreq = 0;
    m_vol = 0; m_st = 0;
    m_aduty = 0; m_avol = 0; m_amode = 0;
    m_pduty = 0; m_pvol = 0; m_pmode = 0;
    m_pflag = 0; m_sd = 0; m_wrap = 0;
    m_wave = 32768;
  endtask

  task automatic model_step();
    bit [32:0] sum;
    bit        adv, carry, end_rel, do_apply;
    if (rst_active_high) begin
      model_reset();
      return;
    end
    if (m_sd) m_wave = exp_wave(m_phase, m_vol, m_aduty, m_amode);
    adv      = sample_en && (m_st != 0);
    sum      = {1'b0, m_phase} + {1'b0, m_afreq};
    carry    = adv && sum[32];
    end_rel  = (m_st == 2) && sample_en && (m_vol <= 1);
    do_apply = m_pflag && (key_on || (m_st == 0) || carry);
    if (sample_en) begin
      if (m_st == 0)      m_vol = 0;
      else if (m_st == 1) m_vol = m_vol + ((m_avol > m_vol) ? 1 : (m_avol < m_vol) ? -1 : 0);
      else                m_vol = (m_vol > 0) ? m_vol - 1 : 0;
    end
    if (key_on)                      m_st = 1;
    else if (m_st == 1 && key_off)   m_st = 2;
    else if (end_rel)                m_st = 0;
    if (key_on || end_rel) begin
      m_phase = 0;
      m_wrap  = 0;
    end else begin
      if (adv) m_phase = sum[31:0];
      m_wrap = carry;
    end
    if (do_apply) begin
      m_afreq = m_pfreq; m_aduty = m_pduty; m_avol = m_pvol; m_amode = m_pmode;
      m_pflag = 0;
    end else if (cfg_valid && !m_pflag) begin
      m_pfreq = cfg_freq; m_pduty = int'(cfg_duty); m_pvol = int'(cfg_vol);
      m_pmode = int'(cfg_mode);
      m_pflag = 1;
    end
    m_sd = sample_en;
  endtask

  // ---------------- checking ----------------
  task automatic cycle_check();
    logic [15:0] ew;
    ew = m_wave[15:0];
    n_cmp++;
    if (wave_out !== ew || wrap !== m_wrap || busy !== (m_st != 0) || cfg_ready !== !m_pflag) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got wave=%h wrap=%b busy=%b ready=%b, expected wave=%h wrap=%b busy=%b ready=%b",
               $time, wave_out, wrap, busy, cfg_ready, ew, m_wrap, (m_st != 0), !m_pflag);
    end
  endtask

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, expv, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle_check();
    #1;
    key_on  = 1'b0;
    key_off = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, cnt2, hi, lo, early;
    model_reset();

    // Model pins from hand arithmetic.
    check("model_pulse_hi", exp_wave(32'h0000_0000, 63, 128, 0), 32'hFDFF);
    check("model_pulse_lo", exp_wave(32'h8000_0000, 63, 128, 0), 32'h0200);
    check("model_saw_min",  exp_wave(32'h0000_0000, 63, 0, 1),   32'h0200);
    check("model_saw_max",  exp_wave(32'hFFFF_0000, 63, 0, 1),   32'hFDFF);
    check("model_vol0",     exp_wave(32'h1234_5678, 0, 200, 1),  32'h8000);

    @(negedge clk); #1;
    tick(); tick();
    rst_active_high = 1'b0;
    tick();
    check("reset_wave",  int'(wave_out), 32'h8000);
    check("reset_ready", int'(cfg_ready), 1);
    check("reset_busy",  int'(busy), 0);
    check("reset_wrap",  int'(wrap), 0);

    // Basic note: freq 2^28, duty 128, vol 63, pulse.
    cfg_valid = 1; cfg_freq = 32'h1000_0000; cfg_duty = 128; cfg_vol = 63; cfg_mode = 0;
    tick();
    cfg_valid = 0;
    check("ready_after_accept", int'(cfg_ready), 0);
    tick();
    check("ready_after_idle_apply", int'(cfg_ready), 1);
    key_on = 1;
    tick();
    check("busy_after_key_on", int'(busy), 1);
    sample_en = 1;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      cnt += int'(wrap);
    end
    check("wraps_in_64_samples", cnt, 4);
    hi = 0; lo = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wave_out == 16'hFDFF) hi++;
      if (wave_out == 16'h0200) lo++;
    end
    check("full_amp_high_samples", hi, 8);
    check("full_amp_low_samples", lo, 8);

    // Release from full volume.
    key_off = 1; sample_en = 0;
    tick();
    sample_en = 1;
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    check("release_sample_count", cnt, 63);
    sample_en = 0;
    tick();
    check("idle_wave_mid", int'(wave_out), 32'h8000);

    // Mid-period frequency change with cfg_valid held.
    key_on = 1;
    tick();
    sample_en = 1;
    for (int i = 0; i < 5; i++) tick();
    sample_en = 0;
    cfg_valid = 1; cfg_freq = 32'h2000_0000; cfg_vol = 63; cfg_duty = 64; cfg_mode = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (cfg_valid && cfg_ready) cnt++;
      tick();
    end
    check("single_accept_while_pending", cnt, 1);
    cfg_valid = 0;
    sample_en = 1;
    cnt = 0; early = 0;
    while (!wrap && cnt < 100) begin
      tick();
      cnt++;
      if (!wrap && cfg_ready) early++;
    end
    check("samples_to_wrap_old_freq", cnt, 11);
    check("ready_early_rises", early, 0);
    check("ready_at_wrap", int'(cfg_ready), 1);
    cnt2 = 0;
    tick(); cnt2++;
    while (!wrap && cnt2 < 100) begin
      tick();
      cnt2++;
    end
    check("new_period_samples", cnt2, 8);

    // key_on and key_off together in RUN.
    sample_en = 0;
    key_on = 1; key_off = 1;
    tick();
    check("both_keys_stays_run", int'(busy), 1);
    sample_en = 1;
    cnt = 0;
    while (!wrap && cnt < 100) begin
      tick();
      cnt++;
    end
    check("restart_phase_period", cnt, 8);

    // Reset mid-note with a pending config.
    cfg_valid = 1; cfg_freq = 32'h4000_0000; cfg_mode = 1;
    tick();
    cfg_valid = 0;
    check("pending_before_reset", int'(cfg_ready), 0);
    tick(); tick();
    rst_active_high = 1;
    tick();
    check("rst_wave",  int'(wave_out), 32'h8000);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_wrap",  int'(wrap), 0);
    rst_active_high = 0;
    tick();
    key_on = 1;
    tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(wrap);
    end
    check("pending_discarded_no_wrap", cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_active_high = ($urandom_range(0, 999) == 0);
      sample_en = ($urandom_range(0, 3) != 0);
      key_on    = ($urandom_range(0, 59) == 0);
      key_off   = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_freq  = $urandom() >> $urandom_range(0, 10);
      cfg_duty  = 8'($urandom());
      cfg_vol   = 6'($urandom_range(0, 63));
      cfg_mode  = 2'($urandom());
      tick();
    end
    rst_active_high = 0;
    sample_en = 0;
    cfg_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_pulse_voice.md
# dds_pulse_voice

Parametrised DDS voice generator for the tracker audio path, successor to the fixed-width square channel. It produces pulse (programmable duty), sawtooth or triangle waveforms from a phase accumulator advanced on a sample strobe. Volume is applied through a click-free slew envelope with key-on/key-off gating. New settings arrive through a valid/ready handshake and take effect only on a phase wrap. Sits between the sequencer register file and the channel mixer; output is offset-binary.

## Interface
- PHASE_WIDTH, 32, phase accumulator and frequency word width (≥ 16)
- OUT_WIDTH, 16, output sample width (≤ 16, ≤ PHASE_WIDTH)
- VOL_WIDTH, 6, volume width; full scale = 2^VOL_WIDTH − 1
- DUTY_WIDTH, 8, pulse duty width (≤ PHASE_WIDTH)
- clk  in  1  clock
- rst_active_high  in  1  reset, asynchronous, active-high
- sample_en  in  1  one-cycle strobe per output sample; phase, envelope and output advance only on it
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
- cfg_freq  in  PHASE_WIDTH  frequency word
- cfg_duty  in  DUTY_WIDTH  pulse high fraction, duty/2^DUTY_WIDTH
- cfg_vol  in  VOL_WIDTH  target volume
- cfg_mode  in  2  0 pulse, 1 saw, 2 triangle, 3 reserved (treated as pulse)
- key_on  in  1  one-cycle note start
- key_off  in  1  one-cycle note release
- wave_out  out  OUT_WIDTH  offset-binary sample
- wrap  out  1  one-cycle pulse when the phase accumulator carries out
- busy  out  1  high when the state is not IDLE

## Operation
- Register sets: pending (written by the handshake) and active (used by the datapath). A pending flag marks unapplied pending data.
- cfg_ready = !pending. An accept loads pending and sets the flag. The flag blocks further accepts until it clears.
- Pending is copied to active on the first cycle that satisfies any of: sample_en with wrap, key_on accepted, or state IDLE. The flag clears in that same cycle.
- States: IDLE, RUN, RELEASE.
- IDLE: phase is held at 0, cur_vol = 0, wave_out = midscale.
- key_on in any state: enter RUN, clear phase to 0, and apply pending if set. cur_vol is kept; attack continues from the current level.
- RUN: on each sample_en, cur_vol moves one step toward active vol, either up or down.
- key_off in RUN: enter RELEASE.
- RELEASE: on each sample_en, cur_vol decrements by 1. Enter IDLE after the sample_en on which cur_vol reaches 0.
- If key_on and key_off arrive in the same cycle, key_on wins. key_off in IDLE or RELEASE is ignored.
- Phase: on sample_en outside IDLE, phase += active freq, modulo 2^PHASE_WIDTH. wrap = carry out.
- Raw signed sample (OUT_WIDTH bits, FS = 2^(OUT_WIDTH−1) − 1):
  - pulse: +FS if phase[top DUTY_WIDTH] < duty, else −FS. duty 0 gives a constant −FS.
  - saw: top OUT_WIDTH phase bits with the MSB inverted, interpreted as signed.
  - triangle: top bit selects fold. The next OUT_WIDTH bits, inverted when folded, minus 2^(OUT_WIDTH−1).
- Scaling: (raw × cur_vol) >>> VOL_WIDTH, computed as a signed full-width product and truncated toward −inf. The offset 2^(OUT_WIDTH−1) is then added, modulo 2^OUT_WIDTH.

## Timing
- Reset values: wave_out = 2^(OUT_WIDTH−1), wrap = 0, busy = 0, cfg_ready = 1. Phase, cur_vol, the active and pending registers, and the pending flag are all 0. State = IDLE.
- sample_en in cycle n updates phase, cur_vol and wrap at edge n+1. wave_out reflects those values at edge n+2.
- wrap is high for exactly one cycle (n+1 to n+2). It is never asserted without a sample_en.
- cfg_ready falls the cycle after an accept and rises the cycle after the apply.
- In IDLE, an accepted config applies on the next edge.
- Reset asserted mid-note returns everything to reset values on that edge, with no fade.
- Without sample_en, all outputs hold.

## Configuration
- DDS_PULSE_VOICE_TRI_EN:
  - Defined: mode 2 produces a triangle.
  - Undefined: the triangle logic is not built and mode 2 behaves as pulse.
- Modes 0, 1 and 3 are unaffected either way.

## Structure
- Package dds_pkg holds:
  - the wave_mode_e enum (PULSE, SAW, TRI, RSVD)
  - the voice_state_e enum (IDLE, RUN, RELEASE)
  - the midscale/FS helper functions parametrised by width
- Sub-module dds_phase_acc: accumulator with enable, synchronous clear and carry-out. It is also reusable by other channels.

## Test plan
- Reset, then key_on, cfg freq 2^28, duty 128, vol 63, pulse. With sample_en every cycle:
  - wrap every 16 samples
  - 8 high / 8 low samples
  - cur_vol reaches 63 after 63 samples
  - final amplitude ±(32767·63)>>>6 around 0x8000
- Freq change offered mid-cycle: cfg_ready low until the wrap, new period starts exactly after the wrap pulse, no short cycle.
- key_off at vol 63: exactly 63 sample_en later busy = 0 and wave_out = 0x8000. key_on during release restarts phase at 0 with no cur_vol jump.
- Simultaneous key_on and key_off in RUN → stays RUN with phase cleared. cfg_valid held while pending → exactly one accept.
- Mode 1 with vol 64−1 → monotonic ramp, wraps at the wrap pulse. Mode 2 without the macro → output identical to mode 0.
- Assert rst_active_high while a config is pending mid-note → all outputs return to reset values on the next edge and the pending config is discarded.
